// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a 16-entry note table as a sequence of note
// dividers with an articulation gap at the end of every note.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   start     in   pulse, begin playback at entry 0 (ignored while busy)
//   stop      in   pulse, abort playback and return to IDLE
//   loop_en   in   1 = restart at entry 0 after the end marker
//   cfg_we    in   note-table write strobe (honoured only in IDLE)
//   cfg_addr  in   [3:0]  note-table entry index
//   cfg_div   in   [21:0] note divider, 0 = rest
//   cfg_len   in   [3:0]  note length in beats, 0 = end-of-melody marker
//   note_div  out  [21:0] divider for the note generator
//   mute      out  1 = downstream audio forced silent
//   busy      out  1 while in LOAD, PLAY or GAP
//   note_idx  out  [3:0]  index of the current entry
//   done      out  one-cycle pulse when the melody ends
module melody_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 12_500_000,
  parameter int unsigned GAP_TICKS      = 1_250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [21:0] cfg_div,
  input  logic [3:0]  cfg_len,
  output logic [21:0] note_div,
  output logic        mute,
  output logic        busy,
  output logic [3:0]  note_idx,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [31:0] TPB = 32'(TICKS_PER_BEAT);
  localparam logic [31:0] GAP = 32'(GAP_TICKS);

  state_t      state, state_nx;
  logic [25:0] note_tbl [16];   // {div[21:0], len[3:0]}
  logic [31:0] cnt, cnt_nx;
  logic [21:0] ent_div, div_nx;
  logic [3:0]  ent_len, idx_nx;
  logic [31:0] play_ticks;
  logic        mute_nx, busy_nx, done_nx;

  assign ent_div = note_tbl[note_idx][25:4];
  assign ent_len = note_tbl[note_idx][3:0];

  // 32-bit product: 15 * 12.5M fits comfortably.
  assign play_ticks = 32'(ent_len) * TPB - GAP;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++) note_tbl[i] <= '0;
    end else if (cfg_we && state == S_IDLE) begin
      note_tbl[cfg_addr] <= {cfg_div, cfg_len};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      note_div <= '0;
      note_idx <= '0;
      mute     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      note_div <= div_nx;
      note_idx <= idx_nx;
      mute     <= mute_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  // Outputs are computed for the state being entered, so every output is
  // a register that matches the registered state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    div_nx   = note_div;
    idx_nx   = note_idx;
    mute_nx  = 1'b1;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_LOAD;
          idx_nx   = '0;
          busy_nx  = 1'b1;
        end
      end

      S_LOAD: begin
        busy_nx = 1'b1;
        if (ent_len != 4'd0) begin
          state_nx = S_PLAY;
          div_nx   = ent_div;
          mute_nx  = (ent_div == 22'd0);
          cnt_nx   = play_ticks - 32'd1;
        end else if (loop_en && note_idx != 4'd0) begin
          state_nx = S_LOAD;
          idx_nx   = '0;
        end else begin
          state_nx = S_DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end

      S_PLAY: begin
        busy_nx = 1'b1;
        if (cnt == 32'd0) begin
          state_nx = S_GAP;
          cnt_nx   = GAP - 32'd1;
        end else begin
          cnt_nx  = cnt - 32'd1;
          mute_nx = (note_div == 22'd0);
        end
      end

      S_GAP: begin
        busy_nx = 1'b1;
        if (cnt == 32'd0) begin
          idx_nx   = note_idx + 4'd1;
          state_nx = S_LOAD;
          // Running off the last entry behaves like hitting an end marker.
          if (note_idx == 4'd15 && !loop_en) begin
            state_nx = S_DONE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (stop) begin
      state_nx = S_IDLE;
      idx_nx   = '0;
      mute_nx  = 1'b1;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed bench for melody_sequencer with
// TICKS_PER_BEAT=10 and GAP_TICKS=2 (8 play + 2 gap cycles per beat).
module tb_melody_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en, cfg_we;
  logic [3:0]  cfg_addr, cfg_len;
  logic [21:0] cfg_div;
  logic [21:0] note_div;
  logic        mute, busy, done;
  logic [3:0]  note_idx;

  int checks = 0;
  int errors = 0;

  melody_sequencer #(.TICKS_PER_BEAT(10), .GAP_TICKS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_div  (cfg_div),
    .cfg_len  (cfg_len),
    .note_div (note_div),
    .mute     (mute),
    .busy     (busy),
    .note_idx (note_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [21:0] d, input logic [3:0] l);
    cfg_we = 1'b1; cfg_addr = a; cfg_div = d; cfg_len = l;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_div = '0; cfg_len = '0;
    step(); step();
    rst = 1'b0;
    check("rst_div",  32'(note_div), 0);
    check("rst_mute", 32'(mute), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_idx",  32'(note_idx), 0);
    check("rst_done", 32'(done), 0);

    // Note, rest, end marker, no loop.
    wr(4'd0, 22'd191571, 4'd2);
    wr(4'd1, 22'd0, 4'd1);
    wr(4'd2, 22'd0, 4'd0);
    start = 1'b1; step(); start = 1'b0;
    check("t1_load_busy", 32'(busy), 1);
    check("t1_load_mute", 32'(mute), 1);
    check("t1_load_idx",  32'(note_idx), 0);
    step();
    check("t1_play_div",  32'(note_div), 191571);
    check("t1_play_mute", 32'(mute), 0);
    repeat (17) step();
    check("t1_play18_mute", 32'(mute), 0);
    step();
    check("t1_gap_mute", 32'(mute), 1);
    check("t1_gap_div",  32'(note_div), 191571);
    check("t1_gap_idx",  32'(note_idx), 0);
    step(); step();
    check("t1_load1_idx",  32'(note_idx), 1);
    check("t1_load1_mute", 32'(mute), 1);
    step();
    check("t1_rest_div",  32'(note_div), 0);
    check("t1_rest_mute", 32'(mute), 1);
    check("t1_rest_busy", 32'(busy), 1);
    repeat (9) step();
    check("t1_rest_end_idx", 32'(note_idx), 1);
    step();
    check("t1_load2_idx", 32'(note_idx), 2);
    check("t1_load2_done", 32'(done), 0);
    step();
    check("t1_done",      32'(done), 1);
    check("t1_done_busy", 32'(busy), 0);
    check("t1_done_mute", 32'(mute), 1);
    step();
    check("t1_idle_done", 32'(done), 0);
    check("t1_idle_busy", 32'(busy), 0);

    // Same table with looping, then stop.
    loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step();
    repeat (17) step();
    step(); step(); step();
    step();
    repeat (10) step();
    check("t2_load2_idx",  32'(note_idx), 2);
    check("t2_load2_done", 32'(done), 0);
    step();
    check("t2_loop_idx",  32'(note_idx), 0);
    check("t2_loop_busy", 32'(busy), 1);
    check("t2_loop_done", 32'(done), 0);
    step();
    check("t2_replay_div",  32'(note_div), 191571);
    check("t2_replay_mute", 32'(mute), 0);
    stop = 1'b1; step(); stop = 1'b0;
    check("t2_stop_busy", 32'(busy), 0);
    check("t2_stop_mute", 32'(mute), 1);
    check("t2_stop_idx",  32'(note_idx), 0);
    check("t2_stop_done", 32'(done), 0);
    step();
    check("t2_stay_idle", 32'(busy), 0);

    // Empty table: entry 0 is an end marker even with looping enabled.
    rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    check("t3_load_busy", 32'(busy), 1);
    step();
    check("t3_done",      32'(done), 1);
    check("t3_done_busy", 32'(busy), 0);
    check("t3_div",       32'(note_div), 0);
    step();
    check("t3_idle_done", 32'(done), 0);
    loop_en = 1'b0;

    // Sixteen one-beat notes, wrap ends the melody.
    for (int i = 0; i < 16; i++) wr(4'(i), 22'(i + 1), 4'd1);
    start = 1'b1; step(); start = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_idx%0d", i),  32'(note_idx), 32'(i));
      check($sformatf("t4_div%0d", i),  32'(note_div), 32'(i + 1));
      check($sformatf("t4_mute%0d", i), 32'(mute), 0);
      repeat (7) step();
      check($sformatf("t4_last%0d", i), 32'(mute), 0);
      step();
      check($sformatf("t4_gap%0d", i),  32'(mute), 1);
      step(); step();
      if (i < 15) begin
        check($sformatf("t4_load%0d", i), 32'(note_idx), 32'(i + 1));
        step();
      end else begin
        check("t4_done",      32'(done), 1);
        check("t4_done_idx",  32'(note_idx), 0);
        check("t4_done_busy", 32'(busy), 0);
      end
    end
    step();
    check("t4_idle_done", 32'(done), 0);

    // Writes and start while playing are ignored.
    start = 1'b1; step(); start = 1'b0;
    step();
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_div = 22'd555; cfg_len = 4'd3; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    check("t5_idx",  32'(note_idx), 0);
    check("t5_div",  32'(note_div), 1);
    repeat (6) step();
    check("t5_last_mute", 32'(mute), 0);
    step();
    check("t5_gap_mute", 32'(mute), 1);
    stop = 1'b1; step(); stop = 1'b0;
    check("t5_stop_busy", 32'(busy), 0);
    start = 1'b1; step(); start = 1'b0;
    step();
    check("t5_replay_div",  32'(note_div), 1);
    check("t5_replay_mute", 32'(mute), 0);
    repeat (7) step();
    check("t5_replay_last", 32'(mute), 0);
    step();
    check("t5_replay_gap", 32'(mute), 1);
    stop = 1'b1; step(); stop = 1'b0;
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("t5_ss_busy", 32'(busy), 0);
    check("t5_ss_mute", 32'(mute), 1);
    step();
    check("t5_ss_stay", 32'(busy), 0);

    // Reset mid-play overrides everything and clears the table.
    start = 1'b1; step(); start = 1'b0;
    step(); repeat (3) step();
    check("t6_mid_mute", 32'(mute), 0);
    rst = 1'b1; start = 1'b1; stop = 1'b1; cfg_we = 1'b1;
    cfg_addr = 4'd0; cfg_div = 22'd99; cfg_len = 4'd2;
    step();
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    check("t6_rst_div",  32'(note_div), 0);
    check("t6_rst_mute", 32'(mute), 1);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_idx",  32'(note_idx), 0);
    check("t6_rst_done", 32'(done), 0);
    start = 1'b1; step(); start = 1'b0;
    step();
    check("t6_empty_done", 32'(done), 1);
    check("t6_empty_div",  32'(note_div), 0);
    step();

    // Write together with start in IDLE is seen by the load.
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_div = 22'd77; cfg_len = 4'd1; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    step();
    check("t7_div",  32'(note_div), 77);
    check("t7_mute", 32'(mute), 0);
    stop = 1'b1; step(); stop = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter TICKS_PER_BEAT, default 12_500_000, clk cycles per beat (8 beats/s at 100 MHz).
REQ-002 Parameter GAP_TICKS, default 1_250_000, silent articulation gap at the end of each note; GAP_TICKS SHALL be ≥1 and < TICKS_PER_BEAT.
REQ-003 clk  input  1  clock from crystal.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse, begin playback at entry 0.
REQ-006 stop  input  1  single-cycle pulse, abort playback.
REQ-007 loop_en  input  1  1 = restart at entry 0 after the end marker instead of finishing.
REQ-008 cfg_we  input  1  note-table write strobe.
REQ-009 cfg_addr  input  4  note-table entry index.
REQ-010 cfg_div  input  22  note divider for the entry; 0 = rest.
REQ-011 cfg_len  input  4  note length in beats; 0 = end-of-melody marker.
REQ-012 note_div  output  22  divider driven to the note generator.
REQ-013 mute  output  1  1 = downstream audio forced silent.
REQ-014 busy  output  1  1 while in LOAD, PLAY or GAP.
REQ-015 note_idx  output  4  index of the current entry.
REQ-016 done  output  1  one-cycle pulse when the melody ends.

Function
REQ-017 Note table SHALL hold 16 entries of {div[21:0], len[3:0]}, written on clk edge when cfg_we=1 and state is IDLE; writes in any other state SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, LOAD, PLAY, GAP, DONE; all outputs registered.
REQ-019 IDLE: start=1 -> LOAD with note_idx=0; otherwise remain.
REQ-020 LOAD (1 cycle): read entry[note_idx]; len≠0 -> PLAY, note_div<=entry.div; len=0 and loop_en=1 and note_idx≠0 -> LOAD with note_idx=0; otherwise -> DONE.
REQ-021 PLAY SHALL last exactly len*TICKS_PER_BEAT−GAP_TICKS cycles, mute=(note_div==0), then -> GAP.
REQ-022 GAP SHALL last exactly GAP_TICKS cycles, mute=1, note_div held; then note_idx<=note_idx+1 and -> LOAD.
REQ-023 At note_idx=15 end of GAP, index SHALL wrap to 0 and be treated as end marker: loop_en=1 -> LOAD idx 0, else -> DONE.
REQ-024 DONE SHALL last 1 cycle with done=1, mute=1, busy=0, then -> IDLE.
REQ-025 mute SHALL be 1 in IDLE, LOAD, GAP, DONE.
REQ-026 Latency: start sampled at edge N -> LOAD during cycle N+1 -> PLAY with new note_div from cycle N+2.
REQ-027 stop=1 in any state SHALL force IDLE on the next edge with mute=1, busy=0, done=0, note_idx=0; stop wins over simultaneous start.
REQ-028 start while busy SHALL be ignored.
REQ-029 Duration product SHALL be computed at ≥28 bits without overflow for len=15 and default TICKS_PER_BEAT.
REQ-030 cfg_we simultaneous with start in IDLE: write SHALL complete; playback SHALL see the written value.

Reset
REQ-031 rst=1 at a clk edge SHALL set state IDLE, note_div=0, mute=1, busy=0, note_idx=0, done=0, all table entries {0,0}, tick counters 0.
REQ-032 rst mid-playback SHALL take effect on the same edge, overriding start, stop and cfg_we.

Verification (TICKS_PER_BEAT=10, GAP_TICKS=2)
REQ-033 Write e0={191571,2}, e1={0,1}, e2 len=0; start -> note_div=191571 mute=0 for 18 cycles, mute=1 2 cycles, rest mute=1 10 cycles, done pulse, idle.
REQ-034 Same table, loop_en=1 -> after e1 GAP, LOAD idx 0 and 191571 replays; done never asserts; stop -> IDLE next cycle, mute=1.
REQ-035 Empty table (after reset) start -> LOAD, DONE (done=1 at cycle N+2), IDLE; note_div stays 0.
REQ-036 All 16 entries len=1, loop_en=0 -> idx 0..15 each 8 play + 2 gap cycles, wrap ends with done.
REQ-037 cfg_we during PLAY to the playing entry -> table unchanged; start during PLAY ignored; start+stop same cycle in IDLE -> stays IDLE.
REQ-038 rst asserted mid-PLAY -> next cycle all outputs at reset values; subsequent start plays nothing (table cleared).
